// File: rtl/master_port_burst.sv
// Bit-serial bus master port with bursts, show-ahead write pop,
// read-data strobe and slave timeout abort.
module master_port_burst #(
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 8,
  parameter  int BURST_MAX = 4,
  parameter  int TIMEOUT   = 255,
  localparam int LEN_W     = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  output logic              last,
  input  logic              m_req,
  output logic              m_ack,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_mode,
  input  logic [LEN_W-1:0]  m_len,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic              m_wr_pop,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_done,
  output logic              m_err
);

  localparam int WMAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BW   = $clog2(WMAX + 1);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BURST_MAX - 1);
  localparam logic [BW-1:0]    A_LAST   = BW'(ADDR_W - 1);
  localparam logic [BW-1:0]    D_LAST   = BW'(DATA_W - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WR, S_RD, S_DONE, S_ERR
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wsh_q;
  logic [DATA_W-1:0] rsh_q;
  logic [DATA_W-1:0] rsh_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              mode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [BW-1:0]     bit_q;
  logic [TW-1:0]     tmo_q;

  logic busy, wr_hs, rd_hs, hs, tmo_hit;
  logic a_end, d_end, last_beat;

  assign busy         = (state_q == S_ADDR) || (state_q == S_WR) ||
                        (state_q == S_RD);
  assign master_valid = (state_q == S_ADDR) || (state_q == S_WR);
  assign master_ready = (state_q == S_RD);
  assign wr_hs        = master_valid & slave_ready;
  assign rd_hs        = master_ready & slave_valid;
  assign hs           = wr_hs | rd_hs;
  assign a_end        = (bit_q == A_LAST);
  assign d_end        = (bit_q == D_LAST);
  assign last_beat    = (beat_q == len_q);
  assign tmo_hit      = (TIMEOUT != 0) && busy && !hs && (tmo_q == TMO_LAST);
  assign rsh_d        = (rsh_q << 1) | DATA_W'(rd_bus);

  assign m_ack      = (state_q == S_IDLE);
  assign m_done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign m_err      = (state_q == S_ERR);
  assign mode       = mode_q;
  assign last       = ((state_q == S_WR) || (state_q == S_RD)) && last_beat;
  assign m_rd_data  = rd_data_q;
  assign m_rd_valid = rd_valid_q;
  assign wr_bus     = (state_q == S_ADDR) ? addr_q[ADDR_W-1] :
                      (state_q == S_WR)   ? wsh_q[DATA_W-1]  : 1'b0;
  // Pop at accept, and on the closing bit of every non-final write beat.
  assign m_wr_pop   = ((state_q == S_IDLE) & m_req & m_mode) |
                      ((state_q == S_WR) & wr_hs & d_end & ~last_beat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wsh_q      <= '0;
      rsh_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      bit_q      <= '0;
      tmo_q      <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (busy && !hs && TIMEOUT != 0)
        tmo_q <= tmo_q + TW'(1);
      else if (hs)
        tmo_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (m_req) begin
            addr_q  <= m_addr;
            mode_q  <= m_mode;
            len_q   <= (m_len > LEN_MAX) ? LEN_MAX : m_len;
            wsh_q   <= m_mode ? m_wr_data : '0;
            rsh_q   <= '0;
            bit_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (tmo_hit) begin
            state_q <= S_ERR;
          end else if (wr_hs) begin
            addr_q <= addr_q << 1;
            if (a_end) begin
              bit_q   <= '0;
              state_q <= mode_q ? S_WR : S_RD;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        S_WR: begin
          if (tmo_hit) begin
            state_q <= S_ERR;
          end else if (wr_hs) begin
            if (d_end) begin
              bit_q <= '0;
              if (last_beat) begin
                state_q <= S_DONE;
              end else begin
                beat_q <= beat_q + LEN_W'(1);
                wsh_q  <= m_wr_data;
              end
            end else begin
              wsh_q <= wsh_q << 1;
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        S_RD: begin
          if (tmo_hit) begin
            state_q <= S_ERR;
          end else if (rd_hs) begin
            if (d_end) begin
              rd_data_q  <= rsh_d;
              rd_valid_q <= 1'b1;
              rsh_q      <= '0;
              bit_q      <= '0;
              if (last_beat)
                state_q <= S_DONE;
              else
                beat_q <= beat_q + LEN_W'(1);
            end else begin
              rsh_q <= rsh_d;
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_port_burst.sv
// Bench for master_port_burst: table vectors, random transfers
// against a bit-stream model, plus timeout and reset sequences.
module tb_master_port_burst;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mode, wr_bus, rd_bus, master_valid, slave_ready;
  logic        master_ready, slave_valid, last, m_req, m_ack;
  logic [15:0] m_addr;
  logic        m_mode;
  logic [1:0]  m_len;
  logic [7:0]  m_wr_data;
  logic        m_wr_pop;
  logic [7:0]  m_rd_data;
  logic        m_rd_valid, m_done, m_err;

  int nerr = 0;
  int nchk = 0;
  logic [7:0] last_rd = 8'h00;
  logic [3:0][7:0] words;

  typedef struct {
    logic [15:0]     addr;
    logic            md;
    logic [1:0]      len;
    logic [3:0][7:0] w;
    int              pat;
    int              exp_pops;
    int              exp_cyc;
  } vec_t;

  vec_t tbl [6];

  master_port_burst #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .rd_bus(rd_bus), .master_valid(master_valid),
    .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .last(last), .m_req(m_req),
    .m_ack(m_ack), .m_addr(m_addr), .m_mode(m_mode), .m_len(m_len),
    .m_wr_data(m_wr_data), .m_wr_pop(m_wr_pop),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
    .m_done(m_done), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the transfer is an address bit stream followed by
  // (len+1) data words; the bench walks it one handshake at a time.
  task automatic run_xfer(input vec_t v);
    int nb, n_addr, n_data, npops, stall, cyc_done, seen_pops;
    bit done_p, rv_p, addr_ph, data_ph, emv, emr, epop, elast, r;
    logic [7:0] rv_w, acc;
    logic ebit;
    words = v.w;
    nb = int'(v.len) + 1;
    n_addr = 0; n_data = 0; npops = 0; stall = 0;
    cyc_done = -1; seen_pops = 0;
    done_p = 0; rv_p = 0; acc = 8'h00; rv_w = 8'h00;
    m_req = 1'b1; m_addr = v.addr; m_mode = v.md; m_len = v.len;
    m_wr_data = words[0];
    @(negedge clk);
    chk("accept_ack", m_ack, 1'b1);
    chk("accept_pop", m_wr_pop, v.md);
    chk("idle_mvalid", master_valid, 1'b0);
    if (m_wr_pop) seen_pops++;
    if (v.md) npops = 1;
    tick();
    m_req = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      addr_ph = n_addr < 16;
      data_ph = !addr_ph && (n_data < nb * 8);
      emv = addr_ph || (data_ph && v.md);
      emr = data_ph && !v.md;
      case (v.pat)
        0: r = 1'b1;
        1: r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (stall >= 4) r = 1'b1;
      stall = r ? 0 : stall + 1;
      slave_ready = r;
      slave_valid = r;
      if (emr && r) rd_bus = words[n_data / 8][7 - n_data % 8];
      else rd_bus = 1'($urandom_range(0, 1));
      m_wr_data = words[npops > 3 ? 3 : npops];
      @(negedge clk);
      ebit = addr_ph ? v.addr[15 - n_addr]
                     : words[n_data / 8][7 - n_data % 8];
      epop = v.md && data_ph && r && (n_data % 8 == 7) &&
             (n_data / 8 != int'(v.len));
      elast = data_ph && (n_data / 8 == int'(v.len));
      if (emv) chk("wr_bus", wr_bus, ebit);
      chk("master_valid", master_valid, emv);
      chk("master_ready", master_ready, emr);
      chk("last", last, elast);
      chk("m_wr_pop", m_wr_pop, epop);
      chk("m_rd_valid", m_rd_valid, rv_p);
      if (rv_p) chk("m_rd_data", m_rd_data, rv_w);
      chk("m_done", m_done, done_p);
      chk("m_err", m_err, 1'b0);
      chk("m_ack_busy", m_ack, 1'b0);
      if (!done_p) chk("mode", mode, v.md);
      if (m_wr_pop) seen_pops++;
      if (epop) npops++;
      if (done_p) begin
        cyc_done = cyc;
        tick();
        break;
      end
      rv_p = 0;
      if (emv && r) begin
        if (addr_ph) n_addr++;
        else n_data++;
        if (!addr_ph && n_data == nb * 8) done_p = 1;
      end else if (emr && r) begin
        acc = {acc[6:0], rd_bus};
        n_data++;
        if (n_data % 8 == 0) begin
          rv_p = 1;
          rv_w = acc;
          last_rd = acc;
        end
        if (n_data == nb * 8) done_p = 1;
      end
      tick();
    end
    chk("done_seen", 32'(cyc_done > 0), 1);
    chk("pop_count", seen_pops, v.exp_pops);
    if (v.exp_cyc != 0) chk("done_cycle", cyc_done, v.exp_cyc);
  endtask

  initial begin
    int errc;
    bit seen_rv, e;
    logic [15:0] ra;
    vec_t rv;
    m_req = 0; m_addr = 0; m_mode = 0; m_len = 0; m_wr_data = 0;
    rd_bus = 0; slave_ready = 0; slave_valid = 0;
    tbl[0] = '{16'hA5C3, 1'b1, 2'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, 0, 1, 25};
    tbl[1] = '{16'h0F0F, 1'b0, 2'd0, {8'h00, 8'h00, 8'h00, 8'h3C}, 1, 0, 0};
    tbl[2] = '{16'h8001, 1'b1, 2'd3, {8'h44, 8'h33, 8'h22, 8'h11}, 0, 4, 49};
    tbl[3] = '{16'h5A5A, 1'b0, 2'd1, {8'h00, 8'h00, 8'hC3, 8'h96}, 2, 0, 0};
    tbl[4] = '{16'hFFFF, 1'b0, 2'd3, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0, 0, 49};
    tbl[5] = '{16'h1357, 1'b1, 2'd2, {8'h00, 8'hE7, 8'h18, 8'hFF}, 2, 3, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", m_ack, 1'b1);
    chk("rst_mvalid", master_valid, 1'b0);
    chk("rst_mready", master_ready, 1'b0);
    chk("rst_rd_data", m_rd_data, 8'h00);
    chk("rst_done", {m_done, m_err, m_rd_valid, last, mode, wr_bus}, 6'b0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

    for (int i = 0; i < 10; i++) begin
      rv.addr = 16'($urandom);
      rv.md   = 1'($urandom_range(0, 1));
      rv.len  = 2'($urandom_range(0, 3));
      rv.w    = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      rv.pat  = 2;
      rv.exp_pops = rv.md ? int'(rv.len) + 1 : 0;
      rv.exp_cyc  = 0;
      run_xfer(rv);
    end

    // Write with the slave never ready: abort after 8 stalled cycles.
    m_req = 1; m_addr = 16'hBEEF; m_mode = 1; m_len = 0;
    m_wr_data = 8'h77; slave_ready = 0; slave_valid = 0;
    @(negedge clk);
    chk("tmo_accept", m_ack, 1'b1);
    tick();
    m_req = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("tmo_wait_mvalid", master_valid, 1'b1);
      chk("tmo_wait_done", m_done, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("tmo_err", {m_done, m_err}, 2'b11);
    chk("tmo_err_mvalid", master_valid, 1'b0);
    chk("tmo_err_ack", m_ack, 1'b0);
    tick();
    @(negedge clk);
    chk("tmo_idle", {m_ack, m_done, m_err}, 3'b100);
    tick();

    // Read aborted after 3 data bits: no partial word delivered.
    m_req = 1; m_addr = 16'h1234; m_mode = 0; m_len = 0;
    slave_ready = 1; slave_valid = 1;
    @(negedge clk);
    tick();
    m_req = 0;
    errc = -1; seen_rv = 0; e = 0;
    for (int c = 1; c <= 40; c++) begin
      slave_valid = (c <= 19);
      rd_bus = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_rd_valid) seen_rv = 1;
      if (m_done) begin
        errc = c;
        e = m_err;
        tick();
        break;
      end
      tick();
    end
    chk("rd_tmo_cycle", errc, 28);
    chk("rd_tmo_err", e, 1'b1);
    chk("rd_tmo_no_valid", seen_rv, 1'b0);
    chk("rd_tmo_hold", m_rd_data, last_rd);

    // Async reset while bit 5 of the address is on the bus.
    ra = 16'hA5C3;
    m_req = 1; m_addr = ra; m_mode = 1; m_len = 0;
    m_wr_data = 8'h5A; slave_ready = 1;
    @(negedge clk);
    tick();
    m_req = 0;
    repeat (5) tick();
    @(negedge clk);
    chk("rst_mid_bit5", wr_bus, ra[10]);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_ack", m_ack, 1'b1);
    chk("rst_mid_outs", {master_valid, wr_bus, mode, last, m_done,
                         m_wr_pop, m_rd_data}, 14'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    last_rd = 8'h00;
    run_xfer(tbl[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
